// File: rtl/ov_pkg.sv
// Shared types and table constants for the OV sensor configuration path.
// State encoding plus the end-marker and delay-tag values used in the register table.
package ov_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_END,
        ST_DELAY,
        ST_DONE,
        ST_ERROR
    } ov_state_t;

    localparam logic [15:0] OV_END_MARKER = 16'hFFFF;
    localparam logic [7:0]  OV_DELAY_TAG  = 8'hFF;

    // A new run may only be launched from a resting state.
    function automatic logic ov_accepts_start(input ov_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/ov_cfg_sequencer.sv
// Walks a {subaddr,data} register table and issues one SCCB write per entry.
// First tr_start rises PWRUP_CYCLES+3 cycles after start; waits on tr_end (with timeout) per transfer.
module ov_cfg_sequencer
    import ov_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR     = 8'h42,
    parameter int          TBL_DEPTH    = 64,
    parameter logic [15:0] PWRUP_CYCLES = 16'd1000,
    parameter logic [15:0] DELAY_UNIT   = 16'd100,
    parameter logic [15:0] TIMEOUT      = 16'd4095,
    localparam int         TBL_AW       = $clog2(TBL_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    output logic [7:0]        addr,
    output logic [7:0]        subaddr,
    output logic [7:0]        w_data,
    output logic              tr_start,
    input  logic              tr_end,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [TBL_AW-1:0] err_idx
);

    ov_state_t         state;
    logic [TBL_AW-1:0] index;
    logic [23:0]       cnt;
    logic [15:0]       tmo;
    logic              last_entry;

    assign last_entry = (index == TBL_AW'(TBL_DEPTH - 1));
    assign tbl_addr   = index;
    assign addr       = DEV_ADDR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            index    <= '0;
            cnt      <= '0;
            tmo      <= '0;
            subaddr  <= '0;
            w_data   <= '0;
            tr_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_idx  <= '0;
        end else if (start && ov_accepts_start(state)) begin
            state <= ST_PWRUP;
            index <= '0;
            cnt   <= 24'(PWRUP_CYCLES);
            busy  <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            case (state)
                ST_PWRUP: begin
                    if (cnt == 24'd0) state <= ST_FETCH;
                    else              cnt   <= cnt - 24'd1;
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    if (tbl_data == OV_END_MARKER) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (tbl_data[15:8] == OV_DELAY_TAG) begin
                        state <= ST_DELAY;
                        cnt   <= 24'(tbl_data[7:0]) * 24'(DELAY_UNIT);
                    end else begin
                        state    <= ST_ISSUE;
                        subaddr  <= tbl_data[15:8];
                        w_data   <= tbl_data[7:0];
                        tr_start <= 1'b1;
                        tmo      <= '0;
                    end
                end
                ST_ISSUE: begin
                    // Completion wins over timeout, including in the entry cycle.
                    if (tr_end) begin
                        tr_start <= 1'b0;
                        state    <= ST_WAIT_END;
                    end else if (tmo == TIMEOUT - 16'd1) begin
                        tr_start <= 1'b0;
                        state    <= ST_ERROR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_idx  <= index;
                    end else begin
                        tmo <= tmo + 16'd1;
                    end
                end
                ST_WAIT_END: begin
                    if (!tr_end) begin
                        if (last_entry) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            index <= index + TBL_AW'(1);
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_DELAY: begin
                    // A zero-count delay still spends exactly one cycle here.
                    if (cnt <= 24'd1) begin
                        if (last_entry) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            index <= index + TBL_AW'(1);
                            state <= ST_FETCH;
                        end
                    end else begin
                        cnt <= cnt - 24'd1;
                    end
                end
                ST_IDLE, ST_DONE, ST_ERROR: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov_cfg_sequencer.sv
// Randomized self-checking bench for ov_cfg_sequencer with a table ROM and SCCB responder.
module tb_ov_cfg_sequencer;

    localparam int P     = 1000;
    localparam int DEPTH = 8;

    logic        clk, reset, start;
    logic [2:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic [7:0]  addr, subaddr, w_data;
    logic        tr_start, tr_end;
    logic        busy, done, error;
    logic [2:0]  err_idx;

    ov_cfg_sequencer #(.TBL_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .addr(addr), .subaddr(subaddr), .w_data(w_data),
        .tr_start(tr_start), .tr_end(tr_end),
        .busy(busy), .done(done), .error(error), .err_idx(err_idx)
    );

    logic [15:0] rom [DEPTH];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got_v, exp_v, cyc);
        end
    endtask

    // SCCB responder: tr_end rises resp_lat cycles after tr_start, falls resp_hold cycles after tr_start drops.
    int resp_lat = 0, resp_hold = 0;
    bit resp_never = 0;
    initial begin
        int rs, rc, rh;
        tr_end = 1'b0;
        rs = 0; rc = 0; rh = 0;
        forever begin
            @(posedge clk); #2;
            if (reset) begin
                tr_end = 1'b0;
                rs = 0;
            end else begin
                if (rs == 0 && tr_start) begin rc = 0; rs = 1; end
                if (rs == 1) begin
                    if (!tr_start) rs = 0;
                    else if (!resp_never && rc >= resp_lat) begin tr_end = 1'b1; rs = 2; rh = 0; end
                    else rc++;
                end
                if (rs == 2 && !tr_start) begin
                    if (rh >= resp_hold) begin tr_end = 1'b0; rs = 0; end
                    else rh++;
                end
            end
        end
    end

    // Transfer monitor.
    logic [23:0] got[$];
    int first_rise = 0, last_rise = 0, last_fall = 0;
    int stab_errs = 0, overlap_errs = 0;
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tr_start && !prev) begin
                if (tr_end) overlap_errs++;
                got.push_back({addr, subaddr, w_data});
                if (got.size() == 1) first_rise = cyc;
                last_rise = cyc;
            end else if (tr_start && prev) begin
                if ({addr, subaddr, w_data} != got[got.size()-1]) stab_errs++;
            end
            if (!tr_start && prev) last_fall = cyc;
            prev = tr_start;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int start_cyc = 0;

    task automatic pulse_start();
        @(posedge clk); #3;
        start = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk); #3;
        start = 1'b0;
    endtask

    task automatic fill_rom(input logic [15:0] v);
        for (int k = 0; k < DEPTH; k++) rom[k] = v;
    endtask

    // Expected transfers and first-issue latency are derived straight from the table rules.
    task automatic run(input int lat, input int hold, input bit never, input bit poke);
        logic [23:0] exp_q[$];
        int exp_lat, n;
        exp_q = {};
        exp_lat = P + 3;
        for (int k = 0; k < DEPTH; k++) begin
            if (rom[k] == 16'hFFFF) break;
            if (rom[k][15:8] == 8'hFF) begin
                if (exp_q.size() == 0)
                    exp_lat += 2 + ((rom[k][7:0] == 8'd0) ? 1 : int'(rom[k][7:0]) * 100);
            end else begin
                exp_q.push_back({8'h42, rom[k]});
            end
        end
        if (never) while (exp_q.size() > 1) void'(exp_q.pop_back());
        resp_lat = lat; resp_hold = hold; resp_never = never;
        got.delete();
        stab_errs = 0; overlap_errs = 0;
        pulse_start();
        check("start_clears_done", done, 0);
        check("start_clears_error", error, 0);
        check("start_sets_busy", busy, 1);
        for (int i = 0; i < 12000; i++) begin
            @(posedge clk); #3;
            if (start) start = 1'b0;
            else if (poke && busy && (i == 200 || i == 1020)) start = 1'b1;
            else if (done || error) break;
        end
        check("run_finished", done | error, 1);
        check("n_xfer", got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int k = 0; k < n; k++) check("xfer", got[k], exp_q[k]);
        check("done", done, !never);
        check("error", error, never);
        check("busy_end", busy, 0);
        check("stable", stab_errs, 0);
        check("no_overlap", overlap_errs, 0);
        if (exp_q.size() > 0 && got.size() > 0)
            check("first_lat", first_rise - start_cyc, exp_lat);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fill_rom(16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("rst_tr_start", tr_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_tbl_addr", tbl_addr, 0);
        check("rst_addr", addr, 8'h42);
        check("rst_subaddr", subaddr, 0);
        check("rst_w_data", w_data, 0);
        check("rst_err_idx", err_idx, 0);
        @(posedge clk); #3;
        reset = 1'b0;

        // Basic two-entry table.
        fill_rom(16'hFFFF);
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        run(20, 0, 0, 0);

        // Leading delay of 3 units.
        fill_rom(16'hFFFF);
        rom[0] = 16'hFF03; rom[1] = 16'h0C00;
        run(10, 0, 0, 0);
        check("delay_min", (first_rise - (start_cyc + P + 2)) >= 300, 1);

        // Zero-count delay.
        fill_rom(16'hFFFF);
        rom[0] = 16'hFF00; rom[1] = 16'h1234;
        run(5, 0, 0, 0);

        // tr_end already high in the issue entry cycle.
        fill_rom(16'hFFFF);
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        run(0, 0, 0, 0);

        // tr_end slow to fall.
        rom[2] = 16'h3A55;
        run(3, 5, 0, 0);

        // Start pulses while busy are ignored.
        run(20, 0, 0, 1);

        // Full table with no end marker stops at the last entry.
        for (int k = 0; k < DEPTH; k++) rom[k] = {8'(8'h10 + k), 8'(k * 3)};
        run(4, 1, 0, 0);

        // Timeout.
        fill_rom(16'hFFFF);
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        run(0, 0, 1, 0);
        check("tmo_len", last_fall - last_rise, 4095);
        check("tmo_err_idx", err_idx, 0);
        check("tmo_tr_start", tr_start, 0);

        // Reset while waiting for tr_end of entry 1 to fall.
        fill_rom(16'hFFFF);
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h3A55;
        resp_lat = 5; resp_hold = 6; resp_never = 0;
        got.delete();
        pulse_start();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #3;
            if (got.size() == 2 && !tr_start) break;
        end
        check("rst_reach_wait", got.size(), 2);
        reset = 1'b1;
        #1;
        check("arst_tr_start", tr_start, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_error", error, 0);
        check("arst_tbl_addr", tbl_addr, 0);
        check("arst_addr", addr, 8'h42);
        check("arst_subaddr", subaddr, 0);
        check("arst_w_data", w_data, 0);
        check("arst_err_idx", err_idx, 0);
        @(posedge clk); #3;
        reset = 1'b0;
        repeat (1200) @(posedge clk);
        #3;
        check("no_resume_xfer", got.size(), 2);
        check("no_resume_busy", busy, 0);
        run(5, 0, 0, 0);

        // Randomized tables.
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < DEPTH; k++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 0)      rom[k] = 16'hFFFF;
                else if (r == 1) rom[k] = {8'hFF, 8'($urandom_range(0, 2))};
                else             rom[k] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
            end
            run($urandom_range(0, 30), $urandom_range(0, 6), 0, t[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
